// File: rtl/plab3_mem_domain_guard_pkg.sv
// Shared types and constants for the memory domain guard: FSM encoding, domain
// values, memory message field widths and type codes.
package plab3_mem_domain_guard_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCheck = 3'd1,
    StFwd   = 3'd2,
    StWait  = 3'd3,
    StResp  = 3'd4,
    StDeny  = 3'd5
  } state_e;

  localparam logic DOM_NS  = 1'b0;
  localparam logic DOM_SEC = 1'b1;

  localparam int unsigned MsgTypeNbits = 3;
  localparam int unsigned MsgTestNbits = 2;

  localparam logic [MsgTypeNbits-1:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [MsgTypeNbits-1:0] MEM_TYPE_WRITE = 3'd1;

  // Byte offset within a 16-byte cacheline; the region check ignores these bits.
  localparam int unsigned LineOffNbits = 4;

  localparam int unsigned DenyCntNbits = 16;

  function automatic int unsigned len_nbits(input int unsigned line_nbits);
    return $clog2(line_nbits / 8);
  endfunction

endpackage

// File: rtl/plab3_mem_domain_guard_region_check.sv
// Combinational access decision: a domain may touch a line only if its
// security level is at least that of the region the line falls in.
module plab3_mem_DomainRegionCheck
  import plab3_mem_domain_guard_pkg::*;
#(
  parameter int unsigned p_line_addr_nbits = 28
) (
  input  logic [p_line_addr_nbits-1:0] line_addr,
  input  logic [p_line_addr_nbits-1:0] base_line,
  input  logic                         domain,
  output logic                         permit
);

  logic region_sec;

  assign region_sec = (line_addr >= base_line) ? DOM_SEC : DOM_NS;
  assign permit     = (domain >= region_sec);

endmodule

// File: rtl/plab3_mem_domain_guard.sv
// Single-outstanding memory port between the cache refill/evict interface and
// main memory, forwarding permitted lines and answering denied ones locally.
module plab3_mem_domain_guard
  import plab3_mem_domain_guard_pkg::*;
#(
  parameter int unsigned             p_opaque_nbits = 8,
  parameter int unsigned             p_addr_nbits   = 32,
  parameter int unsigned             p_line_nbits   = 128,
  parameter logic [p_addr_nbits-1:0] p_base_rst     = 32'h0001_0000,
  localparam int unsigned LenNbits  = len_nbits(p_line_nbits),
  localparam int unsigned ReqNbits  = MsgTypeNbits + p_opaque_nbits + p_addr_nbits + LenNbits
                                      + p_line_nbits,
  localparam int unsigned RespNbits = MsgTypeNbits + p_opaque_nbits + MsgTestNbits + LenNbits
                                      + p_line_nbits
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    cachemem_req_val,
  output logic                    cachemem_req_rdy,
  input  logic [ReqNbits-1:0]     cachemem_req_msg,
  input  logic                    cachemem_req_domain,

  output logic                    cachemem_resp_val,
  input  logic                    cachemem_resp_rdy,
  output logic [RespNbits-1:0]    cachemem_resp_msg,
  output logic                    cachemem_resp_domain,

  output logic                    mem_req_val,
  input  logic                    mem_req_rdy,
  output logic [ReqNbits-1:0]     mem_req_msg,
  output logic                    mem_req_domain,

  input  logic                    mem_resp_val,
  output logic                    mem_resp_rdy,
  input  logic [RespNbits-1:0]    mem_resp_msg,

  input  logic                    cfg_en,
  input  logic                    cfg_domain,
  input  logic [p_addr_nbits-1:0] cfg_base,

  output logic [DenyCntNbits-1:0] deny_count
);

  localparam int unsigned LineNbits = p_addr_nbits - LineOffNbits;
  localparam int unsigned AddrLsb   = p_line_nbits + LenNbits;
  localparam int unsigned LineLsb   = AddrLsb + LineOffNbits;
  localparam int unsigned OpqLsb    = AddrLsb + p_addr_nbits;

  state_e                    state_q, state_d;
  logic [ReqNbits-1:0]       req_q;
  logic                      dom_q;
  logic [RespNbits-1:0]      resp_q;
  logic [LineNbits-1:0]      base_line_q;
  logic [DenyCntNbits-1:0]   deny_cnt_q;
  logic                      accept_en_q;

  logic                      req_fire;
  logic                      resp_fire;
  logic                      deny_inc;
  logic                      permit;

  logic [LineNbits-1:0]      req_line;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [MsgTypeNbits-1:0]   req_type;
  logic [RespNbits-1:0]      deny_msg;

  assign req_line   = req_q[LineLsb +: LineNbits];
  assign req_opaque = req_q[OpqLsb +: p_opaque_nbits];
  assign req_type   = req_q[ReqNbits-1 -: MsgTypeNbits];

  // Local answer for a denied access: echo type and opaque, no payload.
  assign deny_msg = {req_type, req_opaque, {MsgTestNbits{1'b0}}, {LenNbits{1'b0}},
                     {p_line_nbits{1'b0}}};

  plab3_mem_DomainRegionCheck #(
    .p_line_addr_nbits(LineNbits)
  ) u_region_check (
    .line_addr(req_line),
    .base_line(base_line_q),
    .domain   (dom_q),
    .permit   (permit)
  );

  always_comb begin
    state_d           = state_q;
    cachemem_req_rdy  = 1'b0;
    mem_req_val       = 1'b0;
    mem_resp_rdy      = 1'b0;
    cachemem_resp_val = 1'b0;
    deny_inc          = 1'b0;
    unique case (state_q)
      StIdle: begin
        cachemem_req_rdy = accept_en_q;
        if (cachemem_req_val && accept_en_q) state_d = StCheck;
      end
      StCheck: begin
        if (permit) begin
          state_d = StFwd;
        end else begin
          state_d  = StDeny;
          deny_inc = 1'b1;
        end
      end
      StFwd: begin
        mem_req_val = 1'b1;
        if (mem_req_rdy) state_d = StWait;
      end
      StWait: begin
        mem_resp_rdy = 1'b1;
        if (mem_resp_val) state_d = StResp;
      end
      StResp: begin
        cachemem_resp_val = 1'b1;
        if (cachemem_resp_rdy) state_d = StIdle;
      end
      StDeny: begin
        cachemem_resp_val = 1'b1;
        if (cachemem_resp_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign req_fire  = (state_q == StIdle) && cachemem_req_val && accept_en_q;
  assign resp_fire = (state_q == StWait) && mem_resp_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      accept_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      accept_en_q <= 1'b1;
    end
  end

  // Latched request/response are cleared on reset so an aborted access leaves no trace.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= '0;
      dom_q  <= DOM_NS;
      resp_q <= '0;
    end else begin
      if (req_fire) begin
        req_q <= cachemem_req_msg;
        dom_q <= cachemem_req_domain;
      end
      if (resp_fire) resp_q <= mem_resp_msg;
    end
  end

  // CHECK reads base_line_q combinationally, so a same-cycle write only affects later checks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_line_q <= p_base_rst[p_addr_nbits-1:LineOffNbits];
    end else if (cfg_en && (cfg_domain == DOM_SEC)) begin
      base_line_q <= cfg_base[p_addr_nbits-1:LineOffNbits];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deny_cnt_q <= '0;
    end else if (deny_inc && (deny_cnt_q != {DenyCntNbits{1'b1}})) begin
      deny_cnt_q <= deny_cnt_q + 1'b1;
    end
  end

  always_comb begin
    cachemem_resp_msg = resp_q;
    if (state_q == StDeny) cachemem_resp_msg = deny_msg;
  end

  assign cachemem_resp_domain = dom_q;
  assign mem_req_msg          = req_q;
  assign mem_req_domain       = dom_q;
  assign deny_count           = deny_cnt_q;

  // The config port carries a full byte address; its line offset is never stored.
  logic unused_cfg_off;
  assign unused_cfg_off = ^cfg_base[LineOffNbits-1:0];

endmodule
